mem_stage: RTL and testbench

//  Pipeline MEM stage, directly downstream of EX: consumes EX's registered ALU result, store data, dest reg, PC+4 and controls.

---
 rtl/mem_stage.sv | 224 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Pipeline MEM stage: byte-lane data memory with sized loads/stores, MEM_LATENCY-cycle access FSM,
// WB pipeline registers and EX forwarding taps. Optional misalignment trap under `MEM_MISALIGN_TRAP_EN`.
module mem_stage #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_BITS   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_ALUOut,
  input  logic [31:0] MEM_DataToWrite,
  input  logic [4:0]  MEM_RegToWrite,
  input  logic [31:0] MEM_PCPlus4,
  input  logic        MEM_C_RegWrite,
  input  logic        MEM_C_DataSource,
  input  logic        MEM_C_MemWrite,
  input  logic [1:0]  MEM_C_Jump,
  input  logic        MEM_C_StoreLoad,
  input  logic [1:0]  MEM_C_Extend,
  input  logic        MEM_C_Halt,
  input  logic        MEM_C_Stall_DB,
  output logic [31:0] MEM_ReadData,
  output logic [31:0] MEM_ALUOut_O,
  output logic [4:0]  MEM_RegToWrite_O,
  output logic [31:0] MEM_PCPlus4_O,
  output logic        MEM_C_RegWrite_O,
  output logic        MEM_C_DataSource_O,
  output logic [1:0]  MEM_C_Jump_O,
  output logic        MEM_C_Halt_O,
  output logic        MEM_C_Stall_O,
  output logic [31:0] MEM_ALUOut_HZ,
  output logic [4:0]  MEM_RegDest_HZ,
  output logic        MEM_C_WriteReg_HZ,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        MEM_Misalign,
`endif
  output logic        MEM_Halted
);

  localparam int CNT_W = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY - 1) : 1;
  localparam int CNT_INIT = (MEM_LATENCY > 1) ? (MEM_LATENCY - 2) : 0;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CNT_INIT);
  localparam bit SINGLE_CYCLE = (MEM_LATENCY == 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_r, state_nxt;
  logic [CNT_W-1:0]       cnt_r, cnt_nxt;
  logic                   memop_s, final_s, stall_s, misalign_s, mem_we_s, halted_r;
  logic [ADDR_BITS-1:0]   word_idx_s;
  logic [3:0]             be_s;
  logic [31:0]            wdata_s, rword_s, rdata_s;
  logic [15:0]            half_s;
  logic [7:0]             byte_s;
  logic [31:0]            mem [0:(2**ADDR_BITS)-1];

  assign memop_s    = MEM_C_DataSource | MEM_C_MemWrite;
  assign word_idx_s = MEM_ALUOut[ADDR_BITS+1:2];
  assign rword_s    = mem[word_idx_s];
  assign stall_s    = memop_s & ~MEM_C_Stall_DB & ~final_s;

  assign MEM_C_Stall_O     = stall_s;
  assign MEM_ALUOut_HZ     = MEM_ALUOut;
  assign MEM_RegDest_HZ    = MEM_RegToWrite;
  assign MEM_C_WriteReg_HZ = MEM_C_RegWrite;
  assign MEM_Halted        = halted_r;

  // Final cycle of an access: the cycle in which stores commit and WB registers load
  always_comb begin
    final_s = 1'b0;
    case (state_r)
      IDLE:    final_s = SINGLE_CYCLE;
      BUSY:    final_s = (cnt_r == '0);
      default: final_s = 1'b0;
    endcase
  end

  // Access FSM next state; debug freeze holds everything
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r;
    if (!MEM_C_Stall_DB) begin
      case (state_r)
        IDLE: begin
          if (memop_s && !SINGLE_CYCLE) begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == '0) begin
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt_r - CNT_W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end else begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Half needs 2-byte alignment, word needs 4-byte alignment
  always_comb begin
    misalign_s = 1'b0;
    case (MEM_C_Extend)
      2'b01:   misalign_s = MEM_ALUOut[0];
      2'b10:   misalign_s = 1'b0;
      default: misalign_s = (MEM_ALUOut[1:0] != 2'b00);
    endcase
  end
`else
  assign misalign_s = 1'b0;
`endif

  // Store lane enables and replicated write data; low address bits beyond the size are ignored
  always_comb begin
    be_s    = 4'b0000;
    wdata_s = 32'h0000_0000;
    case (MEM_C_Extend)
      2'b01: begin
        be_s    = MEM_ALUOut[1] ? 4'b1100 : 4'b0011;
        wdata_s = {2{MEM_DataToWrite[15:0]}};
      end
      2'b10: begin
        be_s    = 4'b0001 << MEM_ALUOut[1:0];
        wdata_s = {4{MEM_DataToWrite[7:0]}};
      end
      default: begin
        be_s    = 4'b1111;
        wdata_s = MEM_DataToWrite;
      end
    endcase
  end

  assign mem_we_s = MEM_C_MemWrite & final_s & ~MEM_C_Stall_DB & ~reset & ~halted_r & ~misalign_s;

  // Data memory, byte-lane writes; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && be_s[i]) begin
        mem[word_idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
      end
    end
  end

  // Load lane select and extension; store-with-load and trapped accesses read 0
  always_comb begin
    half_s  = MEM_ALUOut[1] ? rword_s[31:16] : rword_s[15:0];
    byte_s  = rword_s[{MEM_ALUOut[1:0], 3'b000} +: 8];
    rdata_s = 32'h0000_0000;
    if (MEM_C_DataSource && !MEM_C_MemWrite && !misalign_s) begin
      case (MEM_C_Extend)
        2'b01:   rdata_s = MEM_C_StoreLoad ? {{16{half_s[15]}}, half_s} : {16'h0000, half_s};
        2'b10:   rdata_s = MEM_C_StoreLoad ? {{24{byte_s[7]}}, byte_s} : {24'h00_0000, byte_s};
        default: rdata_s = rword_s;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misal_r;
  assign MEM_Misalign = misal_r;
`endif

  // WB pipeline registers; a stall cycle holds data and sends a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      MEM_ReadData       <= 32'h0000_0000;
      MEM_ALUOut_O       <= 32'h0000_0000;
      MEM_RegToWrite_O   <= 5'd0;
      MEM_PCPlus4_O      <= 32'h0000_0000;
      MEM_C_RegWrite_O   <= 1'b0;
      MEM_C_DataSource_O <= 1'b0;
      MEM_C_Jump_O       <= 2'b00;
      MEM_C_Halt_O       <= 1'b0;
      halted_r           <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misal_r            <= 1'b0;
`endif
    end else if (!MEM_C_Stall_DB) begin
      if (stall_s) begin
        MEM_C_RegWrite_O   <= 1'b0;
        MEM_C_DataSource_O <= 1'b0;
        MEM_C_Jump_O       <= 2'b00;
        MEM_C_Halt_O       <= 1'b0;
      end else begin
        MEM_ReadData       <= rdata_s;
        MEM_ALUOut_O       <= MEM_ALUOut;
        MEM_RegToWrite_O   <= MEM_RegToWrite;
        MEM_PCPlus4_O      <= MEM_PCPlus4;
        MEM_C_RegWrite_O   <= MEM_C_RegWrite;
        MEM_C_DataSource_O <= MEM_C_DataSource;
        MEM_C_Jump_O       <= MEM_C_Jump;
        MEM_C_Halt_O       <= MEM_C_Halt;
        halted_r           <= halted_r | MEM_C_Halt;
`ifdef MEM_MISALIGN_TRAP_EN
        misal_r            <= misal_r | (memop_s & misalign_s);
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table, hand-written stall/reset/halt sequences,
// and randomized accesses against a byte-addressed reference memory.
module tb_mem_stage;
  localparam int LAT = 2;
  localparam int AB  = 8;
  localparam int NBYTES = 4 * (2 ** AB);

  logic        clk = 1'b0, reset;
  logic [31:0] alu, wdat, pc4;
  logic [4:0]  rdst;
  logic        regw, dsrc, memw, sl, halt, sdb;
  logic [1:0]  jmp, ext;
  logic [31:0] rd_o, alu_o, pc4_o, alu_hz;
  logic [4:0]  rdst_o, rdest_hz;
  logic        regw_o, dsrc_o, halt_o, stall_o, wreg_hz, halted;
  logic [1:0]  jmp_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misal;
`endif

  mem_stage #(.MEM_LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .MEM_ALUOut(alu), .MEM_DataToWrite(wdat), .MEM_RegToWrite(rdst),
    .MEM_PCPlus4(pc4), .MEM_C_RegWrite(regw), .MEM_C_DataSource(dsrc), .MEM_C_MemWrite(memw),
    .MEM_C_Jump(jmp), .MEM_C_StoreLoad(sl), .MEM_C_Extend(ext), .MEM_C_Halt(halt),
    .MEM_C_Stall_DB(sdb), .MEM_ReadData(rd_o), .MEM_ALUOut_O(alu_o), .MEM_RegToWrite_O(rdst_o),
    .MEM_PCPlus4_O(pc4_o), .MEM_C_RegWrite_O(regw_o), .MEM_C_DataSource_O(dsrc_o),
    .MEM_C_Jump_O(jmp_o), .MEM_C_Halt_O(halt_o), .MEM_C_Stall_O(stall_o), .MEM_ALUOut_HZ(alu_hz),
    .MEM_RegDest_HZ(rdest_hz), .MEM_C_WriteReg_HZ(wreg_hz),
`ifdef MEM_MISALIGN_TRAP_EN
    .MEM_Misalign(misal),
`endif
    .MEM_Halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [7:0] mb [0:NBYTES-1];
  logic m_halted = 1'b0;
  logic m_misal  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, size in bytes, little-endian assembly
  function automatic logic [31:0] model_access(input logic [31:0] a, input logic [31:0] d,
                                               input logic ld, input logic st, input logic s,
                                               input logic [1:0] e);
    int n, base;
    logic [31:0] v;
    logic mis;
    n = (e == 2'b01) ? 2 : (e == 2'b10) ? 1 : 4;
    base = int'(a[AB+1:0]);
    mis = (base % n) != 0;
    base = base - (base % n);
    v = 32'h0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((ld || st) && mis) begin
      m_misal = 1'b1;
      return 32'h0;
    end
`endif
    if (st) begin
      if (!m_halted) for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
      return 32'h0;
    end
    if (!ld) return 32'h0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mb[base + i];
    if (s && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (s && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic ld, input logic st,
                       input logic s, input logic [1:0] e, input logic h);
    alu = a; wdat = d; dsrc = ld; memw = st; sl = s; ext = e; halt = h;
    rdst = 5'($urandom_range(0, 31)); pc4 = $urandom; regw = 1'($urandom); jmp = 2'($urandom);
  endtask

  // One instruction through MEM; caller is just after a posedge
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic ld, input logic st, input logic s, input logic [1:0] e,
                       input logic h, input logic use_exp, input logic [31:0] exp);
    logic [31:0] mexp;
    logic seen, done;
    int stalls;
    drive(a, d, ld, st, s, e, h);
    mexp = model_access(a, d, ld, st, s, e);
    if (use_exp) mexp = exp;
    stalls = 0; done = 1'b0;
    @(negedge clk);
    chk({nm, ".hz"}, {alu_hz ^ {27'h0, rdest_hz}, 31'h0, wreg_hz}, {a ^ {27'h0, rdst}, 31'h0, regw});
    for (int c = 0; c < 20 && !done; c++) begin
      if (c != 0) @(negedge clk);
      seen = stall_o;
      @(posedge clk); #1;
      if (seen) begin
        stalls++;
        chk({nm, ".bubble"}, {28'h0, regw_o, dsrc_o, halt_o, |jmp_o}, 32'h0);
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      bad++; total++;
      $display("FAIL %s.timeout: stall still high after 20 cycles", nm);
    end
    if (h) m_halted = 1'b1;
    chk({nm, ".stalls"}, 32'(stalls), (ld || st) ? 32'(LAT - 1) : 32'h0);
    chk({nm, ".rd"}, rd_o, mexp);
    chk({nm, ".alu"}, alu_o, a);
    chk({nm, ".ctl"}, {pc4_o[15:0], 3'b0, rdst_o, 3'b0, regw_o, dsrc_o, jmp_o, halt_o},
        {pc4[15:0], 3'b0, rdst, 3'b0, regw, ld, jmp, h});
    chk({nm, ".halted"}, {31'h0, halted}, {31'h0, m_halted});
`ifdef MEM_MISALIGN_TRAP_EN
    chk({nm, ".misal"}, {31'h0, misal}, {31'h0, m_misal});
`endif
  endtask

  typedef struct {
    logic [31:0] a, d;
    logic ld, st, s;
    logic [1:0] e;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [18];

  logic [31:0] prev, ra, rdv;
  logic rl, rs;

  initial begin
    tbl[0]  = '{32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0};
    tbl[1]  = '{32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF};
    tbl[2]  = '{32'h10,  32'h0,        1'b0, 1'b1, 1'b0, 2'b00, 32'h0};
    tbl[3]  = '{32'h13,  32'h55AA5580, 1'b0, 1'b1, 1'b0, 2'b10, 32'h0};
    tbl[4]  = '{32'h13,  32'h0,        1'b1, 1'b0, 1'b1, 2'b10, 32'hFFFFFF80};
    tbl[5]  = '{32'h13,  32'h0,        1'b1, 1'b0, 1'b0, 2'b10, 32'h00000080};
    tbl[6]  = '{32'h10,  32'h0,        1'b1, 1'b0, 1'b1, 2'b00, 32'h80000000};
    tbl[7]  = '{32'h22,  32'hFFFF1234, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0};
    tbl[8]  = '{32'h22,  32'h0,        1'b1, 1'b0, 1'b1, 2'b01, 32'h00001234};
    tbl[9]  = '{32'h20,  32'h00008001, 1'b0, 1'b1, 1'b0, 2'b01, 32'h0};
    tbl[10] = '{32'h20,  32'h0,        1'b1, 1'b0, 1'b1, 2'b01, 32'hFFFF8001};
    tbl[11] = '{32'h20,  32'h0,        1'b1, 1'b0, 1'b0, 2'b01, 32'h00008001};
    tbl[12] = '{32'h20,  32'h0,        1'b1, 1'b0, 1'b0, 2'b11, 32'h12348001};
    tbl[13] = '{32'h12345678, 32'h0,   1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
    tbl[14] = '{32'h50,  32'h11223344, 1'b1, 1'b1, 1'b0, 2'b00, 32'h0};
    tbl[15] = '{32'h50,  32'h0,        1'b1, 1'b0, 1'b0, 2'b00, 32'h11223344};
    tbl[16] = '{32'h410, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0};
    tbl[17] = '{32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 2'b00, 32'hA5A5A5A5};

    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    reset = 1'b1; sdb = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    regw = 1'b0; jmp = 2'b00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset.data", rd_o | alu_o | pc4_o, 32'h0);
    chk("reset.ctl", {25'h0, rdst_o, regw_o, dsrc_o}, 32'h0);
    chk("reset.flags", {28'h0, jmp_o, halt_o, halted}, 32'h0);

    // Known contents for the region the random phase touches
    for (int w = 0; w < 32; w++) do_op("init", 32'(4 * w), 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);

    for (int i = 0; i < 18; i++)
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].ld, tbl[i].st, tbl[i].s, tbl[i].e,
            1'b0, 1'b1, tbl[i].exp);

    // Debug freeze in the middle of a store
    prev = alu_o;
    drive(32'h60, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    rdv = model_access(32'h60, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 2'b00);
    @(negedge clk); chk("frz.stall0", {31'h0, stall_o}, 32'h1);
    @(posedge clk); #1 sdb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("frz.stall", {31'h0, stall_o}, 32'h0);
      chk("frz.alu", alu_o, prev);
      @(posedge clk); #1;
    end
    sdb = 1'b0;
    @(negedge clk); chk("frz.final", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("frz.done", {alu_o[30:0], regw_o}, {31'h60, regw});
    do_op("frz.ld", 32'h60, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'hCAFEF00D);

    // Reset aborts an in-flight store
    do_op("rst.pre", 32'h70, 32'h11111111, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    drive(32'h70, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk); chk("rst.stall", {31'h0, stall_o}, 32'h1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("rst.out", {alu_o[30:0], regw_o}, 32'h0);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(posedge clk); #1;
    do_op("rst.ld", 32'h70, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h11111111);

    // Misaligned word store: trapped or forced aligned depending on build
    do_op("mis.st", 32'h41, 32'h55667788, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    do_op("mis.ld", 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h00000000);
`else
    do_op("mis.ld", 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h55667788);
`endif

    for (int i = 0; i < 300; i++) begin
      ra = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
      rl = 1'($urandom_range(0, 2) == 0);
      rs = 1'($urandom_range(0, 2) == 0);
      do_op("rnd", ra, $urandom, rl, rs, 1'($urandom), 2'($urandom), 1'b0, 1'b0, 32'h0);
    end

    // Halt retires, later stores are dropped
    do_op("hlt.pre", 32'h30, 32'h01020304, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h0);
    do_op("hlt.op", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    do_op("hlt.st", 32'h30, 32'h99999999, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    do_op("hlt.ld", 32'h30, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h01020304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
